// File: rtl/mips_pipe_top_level.sv
// mips_pipe_top_level: 5-stage MIPS-subset core (IF/ID/EX/MEM/WB) with external
// instruction and data memories. Branches and jumps resolve in ID with a one-cycle flush.
// Build option: define FORWARDING_EN for EX/ID forwarding. Without it, the hazard unit
// holds ID until every producer of its sources has reached WB.
module mips_pipe_top_level #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          RF_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_adr,
    input  logic [31:0] inst,
    output logic [31:0] data_adr,
    output logic [31:0] data_out,
    input  logic [31:0] data_in,
    output logic        mem_write,
    output logic        mem_read
);
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_e;
    typedef struct packed {
        logic we; logic mr; logic mw; logic imm_sel; logic link; alu_e alu;
    } ctrl_t;

    logic [31:0] pc, if_id_inst, if_id_pc4;
    ctrl_t       id_ex_c;
    logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_pc4;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dst;
    logic        ex_mem_we, ex_mem_mr, ex_mem_mw;
    logic [31:0] ex_mem_alu, ex_mem_st;
    logic [4:0]  ex_mem_dst;
    logic        mem_wb_we, mem_wb_mr;
    logic [31:0] mem_wb_alu, mem_wb_ld;
    logic [4:0]  mem_wb_dst;
    logic [31:0] rf [RF_DEPTH];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] imm_x, rf_a, rf_b, cmp_a, cmp_b, wb_val, tgt, fwd_a, fwd_b, alu_b, alu_y;
    ctrl_t       dc;
    logic        use_rs, use_rt, is_beq, is_bne, is_j, is_jr, is_cmp, stall, redirect;
    logic        ex_rs, ex_rt, mem_rs, mem_rt;
    logic        unused_bits;

    assign op     = if_id_inst[31:26];
    assign rs     = if_id_inst[25:21];
    assign rt     = if_id_inst[20:16];
    assign rd     = if_id_inst[15:11];
    assign funct  = if_id_inst[5:0];
    assign imm_x  = {{16{if_id_inst[15]}}, if_id_inst[15:0]};
    assign unused_bits = &{1'b0, if_id_inst[10:6], id_ex_rs, id_ex_rt};

    // ID decode: control word, destination register and operand usage
    always_comb begin
        dc = '0;
        dst = rd;
        use_rs = 1'b0; use_rt = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jr = 1'b0;
        case (op)
            6'h00: begin
                use_rs = 1'b1; use_rt = 1'b1; dc.we = 1'b1;
                case (funct)
                    6'h20: dc.alu = ALU_ADD;
                    6'h22: dc.alu = ALU_SUB;
                    6'h24: dc.alu = ALU_AND;
                    6'h25: dc.alu = ALU_OR;
                    6'h2A: dc.alu = ALU_SLT;
                    6'h08: begin dc.we = 1'b0; use_rt = 1'b0; is_jr = 1'b1; end
                    default: begin dc.we = 1'b0; use_rs = 1'b0; use_rt = 1'b0; end
                endcase
            end
            6'h08: begin dc.we = 1'b1; dc.imm_sel = 1'b1; dst = rt; use_rs = 1'b1; end
            6'h0A: begin dc.we = 1'b1; dc.imm_sel = 1'b1; dc.alu = ALU_SLT; dst = rt; use_rs = 1'b1; end
            6'h23: begin dc.we = 1'b1; dc.mr = 1'b1; dc.imm_sel = 1'b1; dst = rt; use_rs = 1'b1; end
            6'h2B: begin dc.mw = 1'b1; dc.imm_sel = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h04: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h05: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
            6'h02: is_j = 1'b1;
            6'h03: begin is_j = 1'b1; dc.we = 1'b1; dc.link = 1'b1; dst = 5'd31; end
            default: ;
        endcase
        // $0 is never a real destination; dropping the write here also keeps hazards clean
        if (dst == 5'd0) dc.we = 1'b0;
    end

    // Register file read with same-cycle WB bypass
    assign wb_val = mem_wb_mr ? mem_wb_ld : mem_wb_alu;
    assign rf_a   = (mem_wb_we && mem_wb_dst == rs) ? wb_val : rf[rs];
    assign rf_b   = (mem_wb_we && mem_wb_dst == rt) ? wb_val : rf[rt];

    assign is_cmp = is_beq | is_bne | is_jr;
    assign ex_rs  = id_ex_c.we && use_rs && id_ex_dst == rs;
    assign ex_rt  = id_ex_c.we && use_rt && id_ex_dst == rt;
    assign mem_rs = ex_mem_we && use_rs && ex_mem_dst == rs;
    assign mem_rt = ex_mem_we && use_rt && ex_mem_dst == rt;

`ifdef FORWARDING_EN
    // Load-use and compare-in-ID hazards; everything else is covered by forwarding
    assign stall = (id_ex_c.mr && (ex_rs || ex_rt)) ||
                   (is_cmp && (ex_rs || ex_rt || (ex_mem_mr && (mem_rs || mem_rt))));
    assign cmp_a = (ex_mem_we && !ex_mem_mr && ex_mem_dst == rs) ? ex_mem_alu : rf_a;
    assign cmp_b = (ex_mem_we && !ex_mem_mr && ex_mem_dst == rt) ? ex_mem_alu : rf_b;
    assign fwd_a = (ex_mem_we && ex_mem_dst == id_ex_rs) ? ex_mem_alu :
                   (mem_wb_we && mem_wb_dst == id_ex_rs) ? wb_val : id_ex_a;
    assign fwd_b = (ex_mem_we && ex_mem_dst == id_ex_rt) ? ex_mem_alu :
                   (mem_wb_we && mem_wb_dst == id_ex_rt) ? wb_val : id_ex_b;
`else
    // Hold ID while any source is still owned by EX or MEM; WB is bypassed into the read
    assign stall = ex_rs || ex_rt || mem_rs || mem_rt;
    assign cmp_a = rf_a;
    assign cmp_b = rf_b;
    assign fwd_a = id_ex_a;
    assign fwd_b = id_ex_b;
`endif

    // Redirect target: jr register, j/jal region jump, or PC-relative branch
    always_comb begin
        if (is_jr)     tgt = cmp_a;
        else if (is_j) tgt = {if_id_pc4[31:28], if_id_inst[25:0], 2'b00};
        else           tgt = if_id_pc4 + {imm_x[29:0], 2'b00};
    end
    assign redirect = !stall && (is_j || is_jr || (is_beq && cmp_a == cmp_b) ||
                                 (is_bne && cmp_a != cmp_b));

    // EX ALU; jal carries its return address through the ALU result
    assign alu_b = id_ex_c.imm_sel ? id_ex_imm : fwd_b;
    always_comb begin
        case (id_ex_c.alu)
            ALU_SUB: alu_y = fwd_a - alu_b;
            ALU_AND: alu_y = fwd_a & alu_b;
            ALU_OR:  alu_y = fwd_a | alu_b;
            ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(alu_b)};
            default: alu_y = fwd_a + alu_b;
        endcase
        if (id_ex_c.link) alu_y = id_ex_pc4;
    end

    // IF stage and IF/ID: hold on stall, flush to NOP on redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC; if_id_inst <= '0; if_id_pc4 <= '0;
        end else if (!stall) begin
            pc         <= redirect ? tgt : pc + 32'd4;
            if_id_inst <= redirect ? 32'd0 : inst;
            if_id_pc4  <= pc + 32'd4;
        end
    end

    // ID/EX: a stall injects a bubble
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            id_ex_c <= '0; id_ex_a <= '0; id_ex_b <= '0; id_ex_imm <= '0; id_ex_pc4 <= '0;
            id_ex_rs <= '0; id_ex_rt <= '0; id_ex_dst <= '0;
        end else begin
            id_ex_c <= dc; id_ex_a <= rf_a; id_ex_b <= rf_b; id_ex_imm <= imm_x;
            id_ex_pc4 <= if_id_pc4; id_ex_rs <= rs; id_ex_rt <= rt; id_ex_dst <= dst;
        end
    end

    // EX/MEM and MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_we <= 1'b0; ex_mem_mr <= 1'b0; ex_mem_mw <= 1'b0;
            ex_mem_alu <= '0; ex_mem_st <= '0; ex_mem_dst <= '0;
            mem_wb_we <= 1'b0; mem_wb_mr <= 1'b0; mem_wb_alu <= '0; mem_wb_ld <= '0; mem_wb_dst <= '0;
        end else begin
            ex_mem_we <= id_ex_c.we; ex_mem_mr <= id_ex_c.mr; ex_mem_mw <= id_ex_c.mw;
            ex_mem_alu <= alu_y; ex_mem_st <= fwd_b; ex_mem_dst <= id_ex_dst;
            mem_wb_we <= ex_mem_we; mem_wb_mr <= ex_mem_mr; mem_wb_alu <= ex_mem_alu;
            mem_wb_ld <= data_in; mem_wb_dst <= ex_mem_dst;
        end
    end

    // Register file write in WB
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else if (mem_wb_we) begin
            rf[mem_wb_dst] <= wb_val;
        end
    end

    assign inst_adr  = pc;
    assign data_adr  = ex_mem_alu;
    assign data_out  = ex_mem_st;
    // Strobes are masked during reset so an in-flight store never lands
    assign mem_write = ex_mem_mw & ~rst;
    assign mem_read  = ex_mem_mr & ~rst;
endmodule

// File: tb/tb_mips_pipe_top_level.sv
// Bench for mips_pipe_top_level: runs directed programs from a local instruction ROM,
// scoreboards every store against expectations queued when each program is loaded.
module tb_mips_pipe_top_level;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct { logic [31:0] adr; logic [31:0] dat; int cyc; } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst_adr, inst, data_adr, data_out, data_in;
    logic        mem_write, mem_read;
    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:1023];
    logic        ld_en = 1'b0;
    int          ld_idx = 0;
    logic [31:0] ld_val = '0;
    st_t         sb[$];
    st_t         mon_e;
    int          errors = 0, checks = 0, cyc = 0;
    int          arr[20] = '{12, 5, 33, -2, 7, 0, -9, 18, 4, -1, 25, 9, -3, 6, 14, 2, 8, -7, 11, 3};

    mips_pipe_top_level dut (
        .clk(clk), .rst(rst), .inst_adr(inst_adr), .inst(inst), .data_adr(data_adr),
        .data_out(data_out), .data_in(data_in), .mem_write(mem_write), .mem_read(mem_read)
    );

    always #5 clk = ~clk;

    assign inst    = imem[inst_adr[9:2]];
    assign data_in = mem_read ? dmem[data_adr[11:2]] : 32'd0;

    // data memory write port, preload port and cycle counter since reset release
    always @(posedge clk) begin
        if (ld_en) dmem[ld_idx] <= ld_val;
        else if (mem_write) dmem[data_adr[11:2]] <= data_out;
        cyc <= rst ? 0 : cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // store monitor: pop the scoreboard on every store strobe
    always @(negedge clk) begin
        if (mem_write) begin
            if (sb.size() == 0) begin
                check("extra_store", {31'd0, mem_write}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("st_adr", data_adr, mon_e.adr);
                check("st_dat", data_out, mon_e.dat);
                check("st_rw_excl", {31'd0, mem_read}, 32'd0);
                if (mon_e.cyc >= 0) check("st_cyc", cyc, mon_e.cyc);
            end
        end
    end

    function automatic logic [31:0] enc_r(input int f, input int rd, input int rs, input int rt);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(f)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int op, input int adr);
        return {6'(op), 26'(adr >> 2)};
    endfunction

    task automatic put(input int adr, input logic [31:0] w);
        imem[adr / 4] = w;
    endtask
    task automatic exp_store(input int adr, input int dat, input int c);
        st_t e;
        e.adr = adr; e.dat = dat; e.cyc = c;
        sb.push_back(e);
    endtask
    task automatic begin_prog();
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
    endtask
    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
        repeat (8) @(negedge clk);
        check({tag, "_drain"}, sb.size(), 32'd0);
        sb.delete();
    endtask
    task automatic run_prog(input string tag);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        int mn, mi;
        // reset + ALU forwarding chain
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
        put(0,  enc_i(8, 1, 0, 5));
        put(4,  enc_i(8, 2, 1, 3));
        put(8,  enc_r(34, 3, 2, 1));
        put(12, enc_i(43, 3, 0, 0));
        put(16, enc_j(2, 16));
        exp_store(0, 3, FWD ? 6 : -1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_inst_adr", inst_adr, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_data_adr", data_adr, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        rst = 1'b0;
        check("pc_0", inst_adr, 32'd0);
        @(negedge clk);
        check("pc_4", inst_adr, 32'd4);
        @(negedge clk);
        check("pc_8", inst_adr, 32'd8);
        wait_done("alu_fwd");

        // load-use
        begin_prog();
        put(0,  enc_i(8, 1, 0, 7));
        put(4,  enc_i(43, 1, 0, 100));
        put(8,  enc_i(35, 4, 0, 100));
        put(12, enc_r(32, 5, 4, 4));
        put(16, enc_i(43, 5, 0, 104));
        put(20, enc_j(2, 20));
        exp_store(100, 7, FWD ? 4 : -1);
        exp_store(104, 14, FWD ? 8 : -1);
        run_prog("load_use");

        // branches, slti, logic ops, unsupported opcode
        begin_prog();
        put(0,  enc_i(8, 7, 0, -1));
        put(4,  enc_i(10, 6, 7, 0));
        put(8,  enc_i(4, 0, 0, 1));
        put(12, enc_i(8, 6, 0, 99));
        put(16, enc_i(5, 0, 0, 1));
        put(20, enc_i(8, 8, 0, 2));
        put(24, enc_i(43, 6, 0, 200));
        put(28, enc_i(43, 8, 0, 204));
        put(32, enc_i(8, 9, 0, 1));
        put(36, enc_i(5, 0, 9, 1));
        put(40, enc_i(8, 8, 0, 77));
        put(44, enc_i(43, 8, 0, 208));
        put(48, enc_r(37, 10, 7, 9));
        put(52, enc_r(36, 11, 7, 9));
        put(56, enc_i(13, 11, 0, 55));
        put(60, enc_i(43, 10, 0, 212));
        put(64, enc_i(43, 11, 0, 216));
        put(68, enc_j(2, 68));
        exp_store(200, 1, -1);
        exp_store(204, 2, -1);
        exp_store(208, 2, -1);
        exp_store(212, -1, -1);
        exp_store(216, 1, -1);
        run_prog("branch");

        // jal / jr
        begin_prog();
        put(0,  enc_j(3, 20));
        put(4,  enc_i(43, 31, 0, 300));
        put(8,  enc_i(43, 10, 0, 304));
        put(12, enc_j(2, 12));
        put(20, enc_i(8, 10, 0, 11));
        put(24, enc_r(8, 0, 31, 0));
        put(28, enc_i(8, 10, 0, 55));
        exp_store(300, 4, -1);
        exp_store(304, 11, -1);
        run_prog("jal_jr");

        // minimum finder over 20 words at 1000
        begin_prog();
        for (int i = 0; i < 20; i++) begin
            ld_en = 1'b1; ld_idx = 250 + i; ld_val = arr[i];
            @(negedge clk);
        end
        ld_en = 1'b0;
        put(0,  enc_i(8, 1, 0, 1000));
        put(4,  enc_i(35, 2, 1, 0));
        put(8,  enc_i(8, 3, 0, 0));
        put(12, enc_i(8, 4, 0, 1));
        put(16, enc_i(8, 5, 0, 20));
        put(20, enc_i(4, 5, 4, 8));
        put(24, enc_i(8, 1, 1, 4));
        put(28, enc_i(35, 6, 1, 0));
        put(32, enc_r(42, 7, 6, 2));
        put(36, enc_i(4, 0, 7, 2));
        put(40, enc_r(32, 2, 6, 0));
        put(44, enc_r(32, 3, 4, 0));
        put(48, enc_i(8, 4, 4, 1));
        put(52, enc_j(2, 20));
        put(56, enc_i(43, 2, 0, 2000));
        put(60, enc_i(43, 3, 0, 2004));
        put(64, enc_j(2, 64));
        mn = arr[0]; mi = 0;
        for (int i = 1; i < 20; i++) if (arr[i] < mn) begin mn = arr[i]; mi = i; end
        exp_store(2000, mn, -1);
        exp_store(2004, mi, -1);
        run_prog("min_find");
        check("min_val_mem", dmem[500], mn);
        check("min_idx_mem", dmem[501], mi);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_pipe_top_level.md
Name: mips_pipe_top_level

Overview:
- 5-stage pipelined MIPS-subset CPU core: IF, ID, EX, MEM, WB.
- Instruction memory and data memory are external. The core drives addresses and strobes, and receives instruction and read data.
- Top-level test program: scan a word array in data memory and store its minimum value and that value's index. The data memory exposes both for checking.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- RF_DEPTH, 32, number of general registers; register 0 is hardwired to zero.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- inst_adr  output  32  byte address of the fetch (PC).
- inst  input  32  instruction word; combinational response to inst_adr in the same cycle.
- data_adr  output  32  data byte address (EX/MEM ALU result).
- data_out  output  32  store data (EX/MEM forwarded rt value).
- data_in  input  32  load data; combinational response to data_adr when mem_read=1.
- mem_write  output  1  store strobe; memory writes on the rising edge.
- mem_read  output  1  load strobe.

Behaviour:
- Reset (rst=1 at a rising edge):
  - PC=RESET_PC.
  - All pipeline registers cleared to NOP: no register write, no memory access.
  - Register file cleared to 0.
  - Outputs after reset: inst_adr=0, mem_read=0, mem_write=0, data_adr=0, data_out=0.
  - Reset mid-operation discards all in-flight instructions; pending stores are not performed.
- Supported ISA (standard MIPS encodings):
  - R-type (opcode 0) by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), jr 0x08.
  - I-type by opcode: addi 0x08, slti 0x0A, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - J-type: j 0x02, jal 0x03.
  - Any other opcode or funct executes as a NOP.
- Arithmetic: 32-bit two's complement, overflow ignored (wraps). Immediates are sign-extended.
- Fetch: PC advances by 4 each cycle unless stalled. Word-aligned byte addresses.
- Branch and jump resolution in ID:
  - beq/bne target = PC+4 + (sext(imm)<<2).
  - j/jal target = {PC+4[31:28], imm26, 2'b00}.
  - jr target = rs.
  - Taken branch or any jump: redirect PC and flush the IF/ID instruction to a NOP. Penalty 1 cycle; no delay slot.
- jal writes PC+4 of the jal instruction to $31 in WB.
- Register file:
  - Two combinational reads, one write on the rising edge in WB.
  - A WB write to the register being read in ID bypasses to the ID read in the same cycle.
  - Writes to $0 are ignored.
- Hazards (with FORWARDING_EN):
  - EX operands are forwarded from EX/MEM (priority) then MEM/WB.
  - Load-use (lw in EX, dependent instruction in ID): stall 1 cycle. Hold PC and IF/ID; insert a bubble into ID/EX.
  - Branch/jr in ID whose source is written by the instruction in EX: stall 1.
  - Branch/jr source produced by lw in MEM: stall 1.
  - Branch/jr source produced by an ALU op in MEM: forward from EX/MEM to the ID comparator.
- Simultaneous events: a stall has priority over a redirect. A branch is resolved only when it is not stalled.
- sw data is the forwarded rt value. mem_read and mem_write are never both 1.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: full forwarding and the stall rules as above.
- Undefined: no forwarding paths.
  - The hazard unit stalls any instruction in ID until every producer of its sources has reached WB.
  - The WB-to-ID register-file bypass still applies.
  - Architectural results are identical; only cycle counts change.

Test Plan:
- Reset: hold rst=1 for 2 cycles -> inst_adr=0, mem_read=0, mem_write=0. Release rst -> inst_adr sequence 0, 4, 8.
- ALU forwarding: addi $1,$0,5; addi $2,$1,3; sub $3,$2,$1; sw $3,0($0) -> memory word 0 = 3, no stall cycles with FORWARDING_EN.
- Load-use: store 7 at address 100; lw $4,100($0); add $5,$4,$4; sw $5,104($0) -> mem[104]=14 with exactly 1 bubble.
- Branch: beq taken over one instruction -> skipped instruction has no effect; bne not taken -> falls through. slti $6,$7,0 with $7=-1 -> $6=1.
- jal/jr: jal to a subroutine that executes jr $31 -> returns to the jal address+4, $31 = jal PC+4.
- Min-finder program over 20 words at address 1000 (min -9 at index 6) -> final stores give mem[2000]=-9, mem[2004]=6; result is identical with FORWARDING_EN undefined.
